// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master round-robin arbiter in front of a single-port
//            synchronous memory; one access per 3-cycle IDLE/ISSUE/RESP pass.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;      // 0 = master 0 won last, 1 = master 1
  logic            read_q, read_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            win0, win1;

  // On a tie the master that did not win last time goes first.
  assign win0 = m0_req && (!m1_req || last_q);
  assign win1 = m1_req && (!m0_req || !last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    read_d  = read_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = S_ISSUE;
          last_d  = win1;
          gnt0_d  = win0;
          gnt1_d  = win1;
          addr_d  = win1 ? m1_addr  : m0_addr;
          wdata_d = win1 ? m1_wdata : m0_wdata;
          we_d    = win1 ? m1_we    : m0_we;
          read_d  = win1 ? !m1_we   : !m0_we;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        state_d = S_IDLE;
        if (read_q) begin
          rdata_d = mem_rdata;
          rv0_d   = !last_q;
          rv1_d   = last_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0_gnt    = gnt0_q;
  assign m1_gnt    = gnt1_q;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
